// File: rtl/relu_maxpool2x2_stream_if.sv
// Stream bundle for relu_maxpool2x2_stream.
// Carries the int8 pixel input stream (in_valid/in_ready/in_data) and the
// pooled output stream (out_valid/out_ready/out_data/out_last).
//   master : the surrounding fabric (drives input beats, accepts outputs)
//   slave  : the pooling block itself
interface relu_maxpool2x2_stream_if;

    logic              in_valid;
    logic              in_ready;
    logic signed [7:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic signed [7:0] out_data;
    logic              out_last;

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  out_last
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output out_last
    );

endinterface

// File: rtl/relu_maxpool2x2_stream.sv
// Streaming ReLU + 2x2 stride-2 max pool over an IMG_W x IMG_H int8 map.
// Pixels arrive in raster order, one per accepted beat. Horizontal pairs are
// reduced into a hold register; even rows park their pair maxima in a
// half-row line buffer, odd rows combine with it and emit one pooled pixel.
// Ports:
//   clk              rising-edge clock
//   rst              synchronous active-high reset
//   bus.in_valid     input beat valid
//   bus.in_ready     combinational: !out_valid || out_ready
//   bus.in_data      signed int8 pixel
//   bus.out_valid    pooled pixel valid (registered)
//   bus.out_ready    downstream accepts
//   bus.out_data     signed int8 pooled pixel (registered)
//   bus.out_last     final pooled pixel of a frame (registered)
module relu_maxpool2x2_stream #(
    parameter int unsigned IMG_W   = 28,
    parameter int unsigned IMG_H   = 28,
    parameter bit          RELU_EN = 1'b1
) (
    input  logic                           clk,
    input  logic                           rst,
    relu_maxpool2x2_stream_if.slave        bus
);

    localparam int unsigned COL_W = (IMG_W > 2) ? $clog2(IMG_W) : 1;
    localparam int unsigned ROW_W = (IMG_H > 2) ? $clog2(IMG_H) : 1;
    localparam int unsigned LB_N  = IMG_W / 2;
    localparam int unsigned LB_W  = (LB_N > 1) ? $clog2(LB_N) : 1;

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

    // Geometry sanity: windows must tile the map exactly.
    if ((IMG_W < 2) || ((IMG_W % 2) != 0)) begin : g_bad_img_w
        $error("relu_maxpool2x2_stream: IMG_W must be even and >= 2");
    end
    if ((IMG_H < 2) || ((IMG_H % 2) != 0)) begin : g_bad_img_h
        $error("relu_maxpool2x2_stream: IMG_H must be even and >= 2");
    end

    logic [COL_W-1:0]  col_q;
    logic [ROW_W-1:0]  row_q;
    logic signed [7:0] hold_q;
    logic signed [7:0] linebuf_q [LB_N];

    logic              out_valid_q;
    logic              out_last_q;
    logic signed [7:0] out_data_q;

    logic              in_ready_c;
    logic              accept_c;
    logic signed [7:0] relu_px_c;
    logic signed [7:0] pair_c;
    logic signed [7:0] lb_rd_c;
    logic signed [7:0] result_c;
    logic [LB_W-1:0]   lb_idx_c;
    logic              col_odd_c;
    logic              row_odd_c;
    logic              frame_end_c;

    // Input is blocked only while a pooled pixel is stalled downstream.
    assign in_ready_c = !out_valid_q || bus.out_ready;
    assign accept_c   = bus.in_valid && in_ready_c;

    // Datapath: ReLU, horizontal max, vertical max. All compares are signed.
    always_comb begin
        relu_px_c   = bus.in_data;
        if (RELU_EN && bus.in_data[7]) begin
            relu_px_c = 8'sd0;
        end
        pair_c      = (hold_q > relu_px_c) ? hold_q : relu_px_c;
        lb_idx_c    = LB_W'(col_q >> 1);
        lb_rd_c     = linebuf_q[lb_idx_c];
        result_c    = (lb_rd_c > pair_c) ? lb_rd_c : pair_c;
        col_odd_c   = col_q[0];
        row_odd_c   = row_q[0];
        frame_end_c = (col_q == COL_LAST) && (row_q == ROW_LAST);
    end

    // Raster position, horizontal hold register and output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            col_q       <= '0;
            row_q       <= '0;
            hold_q      <= 8'sd0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= 8'sd0;
        end else begin
            // Drain first; a load on the same edge overrides it below.
            if (out_valid_q && bus.out_ready) begin
                out_valid_q <= 1'b0;
                out_last_q  <= 1'b0;
            end

            if (accept_c) begin
                if (col_q == COL_LAST) begin
                    col_q <= '0;
                    row_q <= (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
                end else begin
                    col_q <= col_q + 1'b1;
                end

                if (!col_odd_c) begin
                    hold_q <= relu_px_c;
                end else if (row_odd_c) begin
                    out_data_q  <= result_c;
                    out_last_q  <= frame_end_c;
                    out_valid_q <= 1'b1;
                end
            end
        end
    end

    // Half-row buffer of pair maxima; written on even rows before any read,
    // so it needs no reset.
    always_ff @(posedge clk) begin
        if (!rst && accept_c && col_odd_c && !row_odd_c) begin
            linebuf_q[lb_idx_c] <= pair_c;
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_q;
    assign bus.out_last  = out_last_q;
    assign bus.out_data  = out_data_q;

endmodule

// File: tb/tb_relu_maxpool2x2_stream.sv
// Bench for relu_maxpool2x2_stream: two instances (ReLU on / off) share one
// 4x4 stimulus stream; a frame-level model predicts every output cycle.
module tb_relu_maxpool2x2_stream;

    localparam int W    = 4;
    localparam int H    = 4;
    localparam int NPIX = W * H;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic signed [7:0] in_data;
    logic              out_ready;

    always #5 clk = ~clk;

    relu_maxpool2x2_stream_if bus_n ();
    relu_maxpool2x2_stream_if bus_r ();

    assign bus_n.in_valid  = in_valid;
    assign bus_n.in_data   = in_data;
    assign bus_n.out_ready = out_ready;
    assign bus_r.in_valid  = in_valid;
    assign bus_r.in_data   = in_data;
    assign bus_r.out_ready = out_ready;

    relu_maxpool2x2_stream #(.IMG_W(W), .IMG_H(H), .RELU_EN(1'b0)) u_dut_n (
        .clk (clk),
        .rst (rst),
        .bus (bus_n.slave)
    );

    relu_maxpool2x2_stream #(.IMG_W(W), .IMG_H(H), .RELU_EN(1'b1)) u_dut_r (
        .clk (clk),
        .rst (rst),
        .bus (bus_r.slave)
    );

    // Index 0 = raw pooling, index 1 = ReLU pooling.
    logic              dv  [2];
    logic              dl  [2];
    logic              dir [2];
    logic signed [7:0] dd  [2];
    assign dv[0]  = bus_n.out_valid;
    assign dv[1]  = bus_r.out_valid;
    assign dl[0]  = bus_n.out_last;
    assign dl[1]  = bus_r.out_last;
    assign dir[0] = bus_n.in_ready;
    assign dir[1] = bus_r.in_ready;
    assign dd[0]  = bus_n.out_data;
    assign dd[1]  = bus_r.out_data;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic signed [31:0] act,
                         input logic signed [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s: wait bound expired (t=%0t)", name, $time);
    endtask

    // ---------------- behavioural model ----------------
    int pix [H][W];
    int pos;
    bit armed = 1'b0;
    bit exp_valid;
    bit exp_last;
    int exp_data [2];
    int qd [2][$];
    int ql [2][$];

    function automatic int relu_of(input int v, input int k);
        return (k == 1 && v < 0) ? 0 : v;
    endfunction

    function automatic int win_max(input int r, input int c, input int k);
        int m = -1000;
        for (int dr = 0; dr < 2; dr++)
            for (int dc = 0; dc < 2; dc++)
                if (relu_of(pix[r-dr][c-dc], k) > m) m = relu_of(pix[r-dr][c-dc], k);
        return m;
    endfunction

    // Compare every cycle mid-period, then advance the model by one edge.
    always @(negedge clk) begin
        bit acc;
        int r;
        int c;
        if (armed) begin
            for (int k = 0; k < 2; k++) begin
                check($sformatf("out_valid[%0d]", k), dv[k], exp_valid);
                check($sformatf("in_ready[%0d]", k), dir[k], (!exp_valid || out_ready));
                if (exp_valid) begin
                    check($sformatf("out_data[%0d]", k), dd[k], exp_data[k]);
                    check($sformatf("out_last[%0d]", k), dl[k], exp_last);
                end
                if (dv[k] === 1'b1 && out_ready === 1'b1) begin
                    qd[k].push_back(int'(dd[k]));
                    ql[k].push_back(int'(dl[k]));
                end
            end
        end
        if (rst) begin
            pos       = 0;
            exp_valid = 1'b0;
            exp_last  = 1'b0;
            armed     = 1'b1;
        end else if (armed) begin
            acc = in_valid && (!exp_valid || out_ready);
            if (exp_valid && out_ready) begin
                exp_valid = 1'b0;
                exp_last  = 1'b0;
            end
            if (acc) begin
                r = pos / W;
                c = pos % W;
                pix[r][c] = int'(in_data);
                if ((r % 2 == 1) && (c % 2 == 1)) begin
                    exp_data[0] = win_max(r, c, 0);
                    exp_data[1] = win_max(r, c, 1);
                    exp_last    = (pos == NPIX - 1);
                    exp_valid   = 1'b1;
                end
                pos = (pos + 1) % NPIX;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send_px(input int v, input int gap_pct);
        bit ok;
        int n;
        while (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
            in_valid = 1'b0;
            in_data  = 8'($urandom);
            @(posedge clk); #1;
        end
        in_valid = 1'b1;
        in_data  = 8'(v);
        n = 0;
        forever begin
            @(negedge clk);
            ok = dir[1];
            @(posedge clk); #1;
            if (ok) break;
            n++;
            if (n >= 200) begin
                fail_now("send_px");
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic send_frame(input int f [NPIX], input int add, input int gap_pct);
        for (int i = 0; i < NPIX; i++) send_px(f[i] + add, gap_pct);
    endtask

    task automatic drain();
        out_ready = 1'b1;
        in_valid  = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
    endtask

    task automatic clear_logs();
        for (int k = 0; k < 2; k++) begin
            qd[k].delete();
            ql[k].delete();
        end
    endtask

    task automatic check_log(input string name, input int k, input int start,
                             input int exp_d [4], input int exp_l [4]);
        for (int i = 0; i < 4; i++) begin
            if (start + i < qd[k].size()) begin
                check($sformatf("%s_data[%0d]", name, start + i), qd[k][start + i], exp_d[i]);
                check($sformatf("%s_last[%0d]", name, start + i), ql[k][start + i], exp_l[i]);
            end else begin
                fail_now($sformatf("%s_missing[%0d]", name, start + i));
            end
        end
    endtask

    int base   [NPIX] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15, 16};
    int ext    [NPIX] = '{-5, -128, -128, 127, -1, -7, -1, 0, -3, -7, 0, 0, -1, -9, 0, 0};
    int e_base [4]    = '{6, 8, 14, 16};
    int e_b2   [4]    = '{26, 28, 34, 36};
    int e_ext_n[4]    = '{-1, 127, -1, 0};
    int e_ext_r[4]    = '{0, 127, 0, 0};
    int l_one  [4]    = '{0, 0, 0, 1};
    int rnd    [NPIX];

    initial begin
        bit done;
        int n;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'sd0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state, in_ready=1 even with out_ready low.
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check($sformatf("rst_out_data[%0d]", k), dd[k], 0);
            check($sformatf("rst_out_last[%0d]", k), dl[k], 0);
            check($sformatf("rst_in_ready[%0d]", k), dir[k], 1);
        end
        @(posedge clk); #1;

        // Basic pooling.
        out_ready = 1'b1;
        clear_logs();
        send_frame(base, 0, 0);
        drain();
        check("basic_count", qd[1].size(), 4);
        check_log("basic_r", 1, 0, e_base, l_one);
        check_log("basic_n", 0, 0, e_base, l_one);

        // ReLU and signed extremes.
        clear_logs();
        send_frame(ext, 0, 0);
        drain();
        check_log("ext_r", 1, 0, e_ext_r, l_one);
        check_log("ext_n", 0, 0, e_ext_n, l_one);

        // Backpressure on the first result.
        clear_logs();
        out_ready = 1'b0;
        fork
            send_frame(base, 0, 0);
            begin
                n = 0;
                do begin
                    @(negedge clk);
                    n++;
                end while (dv[1] !== 1'b1 && n < 100);
                if (n >= 100) fail_now("bp_wait_valid");
                for (int i = 0; i < 5; i++) begin
                    if (i > 0) @(negedge clk);
                    check("bp_hold_data", dd[1], 6);
                    check("bp_in_ready", dir[1], 0);
                end
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        drain();
        check("bp_count", qd[1].size(), 4);
        check_log("bp", 1, 0, e_base, l_one);

        // Input bubbles.
        clear_logs();
        send_frame(base, 0, 50);
        drain();
        check("bub_count", qd[1].size(), 4);
        check_log("bub", 1, 0, e_base, l_one);

        // Reset mid-frame with a pending, stalled output.
        clear_logs();
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) send_px(base[i], 0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid_valid", dv[1], 0);
        @(posedge clk); #1;
        out_ready = 1'b1;
        send_frame(base, 0, 0);
        drain();
        check("rst_mid_count", qd[1].size(), 4);
        check_log("rst_mid", 1, 0, e_base, l_one);

        // Back-to-back frames.
        clear_logs();
        send_frame(base, 0, 0);
        send_frame(base, 20, 0);
        drain();
        check("b2b_count", qd[1].size(), 8);
        check_log("b2b_a", 1, 0, e_base, l_one);
        check_log("b2b_b", 1, 4, e_b2, l_one);

        // Random frames, random gaps and random downstream stalls.
        clear_logs();
        done = 1'b0;
        fork
            begin
                for (int f = 0; f < 3; f++) begin
                    for (int i = 0; i < NPIX; i++) rnd[i] = int'($signed(8'($urandom)));
                    send_frame(rnd, 0, 30);
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk); #1;
                    out_ready = 1'($urandom_range(1));
                end
            end
        join
        drain();
        check("rand_count_r", qd[1].size(), 12);
        check("rand_count_n", qd[0].size(), 12);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/relu_maxpool2x2_stream.md
Name: relu_maxpool2x2_stream

Overview:
- Streaming post-convolution stage that consumes the saturated signed int8 output stream of the conv saturating adder, one pixel per accepted beat, in raster order.
- Applies optional ReLU, then 2x2 stride-2 max pooling over an IMG_W x IMG_H feature map.
- Emits one int8 pooled pixel per 2x2 window to the next layer.
- Buffers one half-row of partial maxima internally; uses valid/ready on both sides.

Parameters:
- IMG_W, 28, feature-map width in pixels; must be even and >= 2. Elaboration error otherwise.
- IMG_H, 28, feature-map height in rows; must be even and >= 2. Elaboration error otherwise.
- RELU_EN, 1, 1 = clamp negative inputs to 0 before pooling; 0 = pool raw signed values.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  in_data valid.
- in_ready  output  1  block can accept a beat; combinational: !out_valid || out_ready.
- in_data  input  8  signed int8 pixel from the saturating adder.
- out_valid  output  1  out_data/out_last valid.
- out_ready  input  1  downstream accepts.
- out_data  output  8  signed int8 pooled pixel.
- out_last  output  1  marks the final pooled pixel of a frame.

Behaviour:
- Reset (sync, rst=1 at a clk edge):
  - out_valid=0, out_data=0, out_last=0.
  - col=0, row=0, hold register=0.
  - in_ready reads 1 after reset.
  - Line-buffer contents are don't-care; every entry is overwritten on an even row before it is read.
- Beat accept:
  - An input beat is accepted when in_valid && in_ready.
  - When no beat is accepted, no counter or buffer changes.
- ReLU: r = (RELU_EN && in_data < 0) ? 0 : in_data.
- Counters:
  - col runs 0..IMG_W-1; row runs 0..IMG_H-1.
  - col advances per accepted beat; row advances on the beat where col==IMG_W-1.
  - Both wrap to 0 after (IMG_H-1, IMG_W-1), so the next beat starts a new frame.
- Horizontal pair:
  - Even col: hold <= r.
  - Odd col: pair = max(hold, r). Signed compare throughout; -128 < 127.
- Vertical pair:
  - Even row, odd col: linebuf[col>>1] <= pair.
  - Odd row, odd col: result = max(linebuf[col>>1], pair).
- Output register:
  - Load on an accepted beat at odd row and odd col, so latency is 1 cycle (out_valid high the cycle after that beat).
  - On load: out_data <= result; out_last <= (row==IMG_H-1 && col==IMG_W-1); out_valid <= 1.
- Output handshake:
  - out_valid && out_ready clears out_valid (and out_last) unless a new result loads the same cycle. A new load wins and keeps out_valid=1.
  - While out_valid && !out_ready: out_data and out_last are held stable, in_ready=0, and no input is accepted.
- Throughput: at most 1 output per 4 inputs; full input rate sustainable when out_ready=1.
- Line buffer: IMG_W/2 entries x 8 bits, registers.
- Widths: no arithmetic widening; max selects an operand, so there is no overflow case.
- Simultaneous events: accepted input and output drain in the same cycle is legal and required (in_ready=1 when out_ready=1).
- Reset mid-frame: any partial window is discarded and any pending output dropped. The first beat after reset is pixel (0,0).

Test Plan:
- Basic pooling: IMG_W=4, IMG_H=4, RELU_EN=1, out_ready=1, rows [1,2,3,4],[5,6,7,8],[9,10,11,12],[13,14,15,16] -> outputs 6,8,14,16 in order; out_last=1 only with 16; each output 1 cycle after its closing beat.
- ReLU and extremes:
  - RELU_EN=1, window [-5,-128,-1,-7] -> 0.
  - Window [-128,127,-1,0] -> 127.
  - RELU_EN=0, window [-3,-7,-1,-9] -> -1.
- Backpressure: hold out_ready=0 when the first result (6) appears -> out_valid stays 1, out_data=6 stable, in_ready=0, in_valid beats not consumed; on release all 4 outputs still 6,8,14,16.
- Input bubbles: random in_valid gaps (~50%) on the scenario-1 frame -> identical output sequence and out_last placement.
- Reset mid-frame: assert rst after 6 accepted beats, then feed the full scenario-1 frame -> exactly 4 outputs 6,8,14,16, no stale output.
- Back-to-back frames: two frames with no gap, second frame = first + 20 -> outputs 6,8,14,16,26,28,34,36; out_last exactly twice (on 16 and 36).
